image_line_feed_ctrl: RTL and testbench

- Frame-level sequencer between a byte-wide pixel source (DMA/FIFO stream) and the imageProcessTop line-buffer filter core.
- Primes the core with PRIME_LINES full lines, then releases one line per core interrupt, then appends PAD_LINES zero lines so the last rows flush.
- Counts filtered output pixels and signals frame completion.

---
 rtl/image_line_feed_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_image_line_feed_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_line_feed_ctrl.sv
// Frame-level sequencer feeding a line-buffer filter core: primes the core
// with a few full lines, releases one line per core interrupt, appends zero
// pad lines to flush the last rows, then waits for all filtered outputs.
module image_line_feed_ctrl #(
  parameter int unsigned IMG_WIDTH   = 512,
  parameter int unsigned IMG_HEIGHT  = 512,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned PAD_LINES   = 2,
  parameter int unsigned LINE_CW     = 10,
  parameter int unsigned PIX_CW      = 19
) (
  input  logic               axi_clk,
  input  logic               axi_reset,
  input  logic               i_start,
  input  logic [7:0]         i_src_data,
  input  logic               i_src_valid,
  output logic               o_src_ready,
  output logic [7:0]         o_pix_data,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  input  logic               i_core_intr,
  input  logic               i_out_valid,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [LINE_CW-1:0] o_lines_sent,
  output logic               o_intr_ovf
);

  localparam logic [LINE_CW-1:0] COL_LAST  = LINE_CW'(IMG_WIDTH - 1);
  localparam logic [LINE_CW-1:0] SRC_LINES = LINE_CW'(IMG_HEIGHT);
  localparam logic [LINE_CW-1:0] ALL_LINES = LINE_CW'(IMG_HEIGHT + PAD_LINES);
  localparam logic [LINE_CW-1:0] PRIME_CNT = LINE_CW'(PRIME_LINES);
  localparam logic [PIX_CW-1:0]  TOTAL_PIX = PIX_CW'(IMG_WIDTH * IMG_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT_INTR,
    S_LINE,
    S_PAD,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [LINE_CW-1:0] col_q, col_d;
  logic [LINE_CW-1:0] lines_q, lines_d;
  logic [PIX_CW-1:0]  out_q, out_d;
  logic [1:0]         pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               intr_q;

  logic               feed;
  logic               pad;
  logic               beat;
  logic               col_wrap;
  logic [LINE_CW-1:0] lines_inc;
  logic               intr_edge;
  logic               consume;

  // Pixel path: source pass-through in feed states, zeros while padding.
  always_comb begin
    feed        = (state_q == S_PRIME) || (state_q == S_LINE);
    pad         = (state_q == S_PAD);
    o_src_ready = feed & i_pix_ready;
    o_pix_valid = (feed & i_src_valid & i_pix_ready) | (pad & i_pix_ready);
    o_pix_data  = feed ? i_src_data : 8'd0;
    beat        = o_pix_valid;
  end

  // Next-state, counters, interrupt bookkeeping and registered outputs.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    lines_d   = lines_q;
    out_d     = out_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    col_wrap  = beat && (col_q == COL_LAST);
    lines_inc = lines_q + LINE_CW'(1);
    intr_edge = i_core_intr && !intr_q && (state_q != S_IDLE);
    consume   = (state_q == S_WAIT_INTR) && (pend_q != 2'd0);

    // Column/line counting shared by feed and pad states.
    if (beat) begin
      col_d = col_wrap ? '0 : col_q + LINE_CW'(1);
      if (col_wrap) begin
        lines_d = lines_inc;
      end
    end

    // Filtered outputs are only counted, saturating at one frame.
    if ((state_q != S_IDLE) && i_out_valid && (out_q != TOTAL_PIX)) begin
      out_d = out_q + PIX_CW'(1);
    end

    // Simultaneous arrival and consumption cancel out.
    if (intr_edge && !consume) begin
      if (pend_q == 2'd3) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 2'd1;
      end
    end else if (!intr_edge && consume) begin
      pend_d = pend_q - 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (PRIME_LINES == 0) ? S_WAIT_INTR : S_PRIME;
          col_d   = '0;
          lines_d = '0;
          out_d   = '0;
          pend_d  = 2'd0;
          ovf_d   = 1'b0;
        end
      end
      S_PRIME: begin
        if (col_wrap && (lines_inc == PRIME_CNT)) begin
          state_d = S_WAIT_INTR;
        end
      end
      S_WAIT_INTR: begin
        if (pend_q != 2'd0) begin
          if (lines_q < SRC_LINES) begin
            state_d = S_LINE;
          end else if (lines_q < ALL_LINES) begin
            state_d = S_PAD;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_LINE: begin
        if (col_wrap) begin
          state_d = S_WAIT_INTR;
        end
      end
      S_PAD: begin
        if (col_wrap) begin
          state_d = (lines_inc == ALL_LINES) ? S_DRAIN : S_WAIT_INTR;
        end
      end
      S_DRAIN: begin
        if (out_q == TOTAL_PIX) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      lines_q <= '0;
      out_q   <= '0;
      pend_q  <= 2'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      lines_q <= lines_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      intr_q  <= i_core_intr;
    end
  end

  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_lines_sent = lines_q;
  assign o_intr_ovf   = ovf_q;

endmodule

// File: tb/tb_image_line_feed_ctrl.sv
// Bench for image_line_feed_ctrl: 8x8 frame, two instances (priming 4 lines
// and priming the whole frame), reference built from the line-release rules.
module tb_image_line_feed_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int PADL = 2;
  localparam int NPIX = W * H;
  localparam int LCW  = 10;
  localparam int PCW  = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, src_valid, pix_ready, core_intr, out_valid;
  logic [7:0] src_data;

  logic           src_ready_a, pix_valid_a, busy_a, done_a, ovf_a;
  logic [7:0]     pix_data_a;
  logic [LCW-1:0] lines_a;
  logic           src_ready_b, pix_valid_b, busy_b, done_b, ovf_b;
  logic [7:0]     pix_data_b;
  logic [LCW-1:0] lines_b;

  image_line_feed_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(4), .PAD_LINES(PADL),
                         .LINE_CW(LCW), .PIX_CW(PCW)) u_dut (
    .axi_clk(clk), .axi_reset(rst), .i_start(start), .i_src_data(src_data),
    .i_src_valid(src_valid), .o_src_ready(src_ready_a), .o_pix_data(pix_data_a),
    .o_pix_valid(pix_valid_a), .i_pix_ready(pix_ready), .i_core_intr(core_intr),
    .i_out_valid(out_valid), .o_busy(busy_a), .o_frame_done(done_a),
    .o_lines_sent(lines_a), .o_intr_ovf(ovf_a));

  image_line_feed_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(8), .PAD_LINES(PADL),
                         .LINE_CW(LCW), .PIX_CW(PCW)) u_dut8 (
    .axi_clk(clk), .axi_reset(rst), .i_start(start), .i_src_data(src_data),
    .i_src_valid(src_valid), .o_src_ready(src_ready_b), .o_pix_data(pix_data_b),
    .o_pix_valid(pix_valid_b), .i_pix_ready(pix_ready), .i_core_intr(core_intr),
    .i_out_valid(out_valid), .o_busy(busy_b), .o_frame_done(done_b),
    .o_lines_sent(lines_b), .o_intr_ovf(ovf_b));

  int tests = 0;
  int fails = 0;

  bit   sel_b, rnd_gap, core_en;
  int   cur_prime;
  logic [7:0] src_mem [0:127];
  int   src_idx, cyc_n, intr_pulses, gate_viol, done_cnt, done_early, out_sent, out_due;
  logic intr_prev, intr_next;
  logic [7:0] got_q [$];
  int   beat_cyc_q [$];

  logic           obs_src_ready, obs_pix_valid, obs_busy, obs_done, obs_ovf;
  logic [7:0]     obs_pix_data;
  logic [LCW-1:0] obs_lines;

  // One clock: drive, sample at negedge, update the reference bookkeeping.
  task automatic cyc();
    int allowed;
    src_valid = rnd_gap ? 1'($urandom_range(0, 1)) : 1'b1;
    pix_ready = rnd_gap ? 1'($urandom_range(0, 1)) : 1'b1;
    src_data  = src_mem[src_idx[6:0]];
    if (core_en) begin
      out_valid = (out_due > 0);
      core_intr = intr_next;
    end
    @(negedge clk);
    obs_src_ready = sel_b ? src_ready_b : src_ready_a;
    obs_pix_valid = sel_b ? pix_valid_b : pix_valid_a;
    obs_pix_data  = sel_b ? pix_data_b  : pix_data_a;
    obs_busy      = sel_b ? busy_b      : busy_a;
    obs_done      = sel_b ? done_b      : done_a;
    obs_ovf       = sel_b ? ovf_b       : ovf_a;
    obs_lines     = sel_b ? lines_b     : lines_a;
    // Source may only be offered while a released source line is unfinished.
    allowed = cur_prime + intr_pulses;
    if (allowed > H) allowed = H;
    if (obs_src_ready && (got_q.size() >= W * allowed)) gate_viol++;
    if (core_intr && !intr_prev) intr_pulses++;
    intr_prev = core_intr;
    if (obs_src_ready && src_valid) src_idx++;
    if (obs_pix_valid) begin
      if (got_q.size() >= 2 * W) out_due++;
      got_q.push_back(obs_pix_data);
      beat_cyc_q.push_back(cyc_n);
    end
    if (out_valid) out_sent++;
    intr_next = 1'b0;
    if (core_en && out_valid) begin
      out_due--;
      if ((out_sent % W) == 0) intr_next = 1'b1;
    end
    if (obs_done) begin
      done_cnt++;
      if (out_sent < NPIX) done_early++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic run_beats(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) cyc();
  endtask

  task automatic pulse();
    core_intr = 1'b1; cyc();
    core_intr = 1'b0; cyc();
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; core_intr = 1'b0; out_valid = 1'b0; core_en = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic begin_frame();
    got_q.delete(); beat_cyc_q.delete();
    src_idx = 0; intr_pulses = 0; gate_viol = 0; done_cnt = 0; done_early = 0;
    out_sent = 0; out_due = 0; intr_next = 1'b0;
    for (int i = 0; i < 128; i++) src_mem[i] = 8'($urandom);
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  function automatic int bc(input int i);
    if (i < beat_cyc_q.size()) return beat_cyc_q[i];
    return -100;
  endfunction

  // Delivered stream must be the source bytes in order, then zeros.
  function automatic int count_mism(input int n_src);
    int m = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      if (k < n_src) begin
        if (got_q[k] !== src_mem[k]) m++;
      end else if (got_q[k] !== 8'd0) m++;
    end
    return m;
  endfunction

  task automatic test_reset();
    sel_b = 0; cur_prime = 4; rnd_gap = 0;
    for (int i = 0; i < 128; i++) src_mem[i] = 8'hA5;
    src_idx = 0;
    rst = 1'b1; start = 1'b0; core_intr = 1'b0; out_valid = 1'b0; core_en = 1'b0;
    cyc(); cyc();
    tests++; if (obs_pix_valid !== 1'b0) begin fails++; $display("FAIL rst_pix_valid: got %b expected 0", obs_pix_valid); end
    tests++; if (obs_src_ready !== 1'b0) begin fails++; $display("FAIL rst_src_ready: got %b expected 0", obs_src_ready); end
    tests++; if (obs_pix_data !== 8'd0) begin fails++; $display("FAIL rst_pix_data: got %h expected 00", obs_pix_data); end
    tests++; if (obs_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", obs_busy); end
    tests++; if (obs_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", obs_done); end
    tests++; if (obs_lines !== 10'd0) begin fails++; $display("FAIL rst_lines: got %0d expected 0", obs_lines); end
    tests++; if (obs_ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b expected 0", obs_ovf); end
    rst = 1'b0; cyc();
    tests++; if (obs_pix_valid !== 1'b0 || obs_busy !== 1'b0) begin fails++; $display("FAIL idle_hold: got valid=%b busy=%b expected 0/0", obs_pix_valid, obs_busy); end
  endtask

  task automatic test_prime_burst();
    reset_dut(); sel_b = 0; cur_prime = 4; rnd_gap = 0;
    begin_frame();
    run_beats(32, 100); run(10);
    tests++; if (got_q.size() !== 32) begin fails++; $display("FAIL prime_beats: got %0d expected 32", got_q.size()); end
    tests++; if (obs_lines !== 10'd4) begin fails++; $display("FAIL prime_lines: got %0d expected 4", obs_lines); end
    tests++; if (obs_busy !== 1'b1 || obs_pix_valid !== 1'b0) begin fails++; $display("FAIL prime_wait: got busy=%b valid=%b expected 1/0", obs_busy, obs_pix_valid); end
    pulse(); run(12);
    tests++; if (got_q.size() !== 40) begin fails++; $display("FAIL burst_beats: got %0d expected 40", got_q.size()); end
    tests++; if (obs_lines !== 10'd5) begin fails++; $display("FAIL burst_lines: got %0d expected 5", obs_lines); end
    tests++; if (bc(39) - bc(32) !== 7) begin fails++; $display("FAIL burst_contig: got span %0d expected 7", bc(39) - bc(32)); end
    tests++; if (count_mism(64) !== 0) begin fails++; $display("FAIL burst_data: got %0d bad bytes expected 0", count_mism(64)); end
  endtask

  task automatic test_back_to_back();
    int c32;
    reset_dut(); sel_b = 0; cur_prime = 4; rnd_gap = 0;
    begin_frame();
    run(3); pulse(); pulse();
    run_beats(32, 100); c32 = bc(31); run(25);
    tests++; if (got_q.size() !== 48) begin fails++; $display("FAIL b2b_beats: got %0d expected 48", got_q.size()); end
    tests++; if (bc(32) !== c32 + 2) begin fails++; $display("FAIL b2b_first_line: got cycle %0d expected %0d", bc(32), c32 + 2); end
    tests++; if (bc(40) !== c32 + 11) begin fails++; $display("FAIL b2b_second_line: got cycle %0d expected %0d", bc(40), c32 + 11); end
    tests++; if (bc(47) !== c32 + 18) begin fails++; $display("FAIL b2b_second_end: got cycle %0d expected %0d", bc(47), c32 + 18); end
    tests++; if (obs_lines !== 10'd6) begin fails++; $display("FAIL b2b_lines: got %0d expected 6", obs_lines); end
    tests++; if (obs_ovf !== 1'b0) begin fails++; $display("FAIL b2b_ovf: got %b expected 0", obs_ovf); end
  endtask

  task automatic test_intr_ovf();
    reset_dut(); sel_b = 0; cur_prime = 4; rnd_gap = 0;
    begin_frame();
    pulse(); pulse(); pulse();
    tests++; if (obs_ovf !== 1'b0) begin fails++; $display("FAIL ovf_at_three: got %b expected 0", obs_ovf); end
    pulse();
    tests++; if (obs_ovf !== 1'b1) begin fails++; $display("FAIL ovf_at_four: got %b expected 1", obs_ovf); end
    run_beats(32, 100); run(40);
    tests++; if (got_q.size() !== 56) begin fails++; $display("FAIL ovf_lines_released: got %0d beats expected 56", got_q.size()); end
    tests++; if (obs_lines !== 10'd7) begin fails++; $display("FAIL ovf_lines: got %0d expected 7", obs_lines); end
    tests++; if (obs_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", obs_ovf); end
  endtask

  task automatic test_same_cycle();
    int c32;
    reset_dut(); sel_b = 0; cur_prime = 4; rnd_gap = 0;
    begin_frame();
    run(2); pulse();
    run_beats(32, 100); c32 = bc(31);
    core_intr = 1'b1; cyc(); core_intr = 1'b0;
    run(25);
    tests++; if (got_q.size() !== 48) begin fails++; $display("FAIL same_cyc_beats: got %0d expected 48", got_q.size()); end
    tests++; if (bc(32) !== c32 + 2) begin fails++; $display("FAIL same_cyc_first: got cycle %0d expected %0d", bc(32), c32 + 2); end
    tests++; if (bc(40) !== c32 + 11) begin fails++; $display("FAIL same_cyc_second: got cycle %0d expected %0d", bc(40), c32 + 11); end
    tests++; if (obs_lines !== 10'd6) begin fails++; $display("FAIL same_cyc_lines: got %0d expected 6", obs_lines); end
  endtask

  task automatic test_start_reset();
    reset_dut(); sel_b = 0; cur_prime = 4; rnd_gap = 0;
    begin_frame();
    run(2); pulse();
    run_beats(35, 100);
    start = 1'b1; cyc(); start = 1'b0;
    run_beats(40, 50); run(5);
    tests++; if (got_q.size() !== 40) begin fails++; $display("FAIL start_ign_beats: got %0d expected 40", got_q.size()); end
    tests++; if (obs_lines !== 10'd5) begin fails++; $display("FAIL start_ign_lines: got %0d expected 5", obs_lines); end
    tests++; if (obs_busy !== 1'b1) begin fails++; $display("FAIL start_ign_busy: got %b expected 1", obs_busy); end
    tests++; if (bc(39) - bc(32) !== 7) begin fails++; $display("FAIL start_ign_contig: got span %0d expected 7", bc(39) - bc(32)); end
    reset_dut();
    begin_frame();
    run_beats(20, 50);
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    tests++; if (obs_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", obs_busy); end
    tests++; if (obs_lines !== 10'd0) begin fails++; $display("FAIL midrst_lines: got %0d expected 0", obs_lines); end
    tests++; if (obs_pix_valid !== 1'b0 || obs_src_ready !== 1'b0) begin fails++; $display("FAIL midrst_feed: got valid=%b ready=%b expected 0/0", obs_pix_valid, obs_src_ready); end
  endtask

  task automatic test_full_frame(input bit do_reset, input bit rnd);
    if (do_reset) reset_dut();
    sel_b = 0; cur_prime = 4; rnd_gap = rnd;
    begin_frame();
    core_en = 1'b1;
    for (int k = 0; k < 4000 && done_cnt == 0; k++) cyc();
    run(10);
    core_en = 1'b0; rnd_gap = 0; out_valid = 1'b0; core_intr = 1'b0;
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL frame_done_count rnd=%0d: got %0d expected 1", rnd, done_cnt); end
    tests++; if (done_early !== 0) begin fails++; $display("FAIL frame_done_early rnd=%0d: got %0d expected 0", rnd, done_early); end
    tests++; if (got_q.size() !== NPIX + PADL * W) begin fails++; $display("FAIL frame_beats rnd=%0d: got %0d expected %0d", rnd, got_q.size(), NPIX + PADL * W); end
    tests++; if (count_mism(NPIX) !== 0) begin fails++; $display("FAIL frame_data rnd=%0d: got %0d bad bytes expected 0", rnd, count_mism(NPIX)); end
    tests++; if (src_idx !== NPIX) begin fails++; $display("FAIL frame_src_used rnd=%0d: got %0d expected %0d", rnd, src_idx, NPIX); end
    tests++; if (obs_lines !== 10'(H + PADL)) begin fails++; $display("FAIL frame_lines rnd=%0d: got %0d expected %0d", rnd, obs_lines, H + PADL); end
    tests++; if (obs_busy !== 1'b0) begin fails++; $display("FAIL frame_idle rnd=%0d: got busy %b expected 0", rnd, obs_busy); end
    tests++; if (gate_viol !== 0) begin fails++; $display("FAIL frame_src_gating rnd=%0d: got %0d early offers expected 0", rnd, gate_viol); end
  endtask

  task automatic test_prime_all();
    reset_dut(); sel_b = 1; cur_prime = 8; rnd_gap = 0;
    begin_frame();
    run_beats(64, 150); run(10);
    tests++; if (got_q.size() !== 64) begin fails++; $display("FAIL p8_prime_beats: got %0d expected 64", got_q.size()); end
    tests++; if (obs_lines !== 10'd8) begin fails++; $display("FAIL p8_prime_lines: got %0d expected 8", obs_lines); end
    pulse(); run(12);
    tests++; if (got_q.size() !== 72) begin fails++; $display("FAIL p8_pad1_beats: got %0d expected 72", got_q.size()); end
    tests++; if (obs_lines !== 10'd9) begin fails++; $display("FAIL p8_pad1_lines: got %0d expected 9", obs_lines); end
    pulse(); run(12);
    tests++; if (got_q.size() !== 80) begin fails++; $display("FAIL p8_pad2_beats: got %0d expected 80", got_q.size()); end
    tests++; if (count_mism(NPIX) !== 0) begin fails++; $display("FAIL p8_data: got %0d bad bytes expected 0", count_mism(NPIX)); end
    tests++; if (obs_busy !== 1'b1 || done_cnt !== 0) begin fails++; $display("FAIL p8_drain_wait: got busy=%b done=%0d expected 1/0", obs_busy, done_cnt); end
    for (int k = 0; k < NPIX - 1; k++) begin out_valid = 1'b1; cyc(); end
    out_valid = 1'b0; run(5);
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL p8_done_before_last: got %0d expected 0", done_cnt); end
    out_valid = 1'b1; cyc(); out_valid = 1'b0; run(5);
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL p8_done_pulse: got %0d expected 1", done_cnt); end
    tests++; if (obs_busy !== 1'b0 || obs_lines !== 10'd10) begin fails++; $display("FAIL p8_final: got busy=%b lines=%0d expected 0/10", obs_busy, obs_lines); end
    sel_b = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; pix_ready = 1'b0; core_intr = 1'b0;
    out_valid = 1'b0; src_data = 8'd0; intr_prev = 1'b0; intr_next = 1'b0;
    sel_b = 0; rnd_gap = 0; core_en = 0; cur_prime = 4; cyc_n = 0; src_idx = 0;
    intr_pulses = 0; gate_viol = 0; done_cnt = 0; done_early = 0; out_sent = 0; out_due = 0;
    test_reset();
    test_prime_burst();
    test_back_to_back();
    test_intr_ovf();
    test_same_cycle();
    test_start_reset();
    test_full_frame(1'b0, 1'b0);
    test_full_frame(1'b1, 1'b1);
    test_full_frame(1'b0, 1'b1);
    test_prime_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
